demux16_rr_arbiter: RTL and testbench
=====================================

DEMUX16_RR_ARBITER -- requirements
Module: demux16_rr_arbiter

Interface
REQ-001 Parameter: UUID, default 0, instance identifier, no functional effect.
REQ-002 Parameter: NAME, default "", instance label, no functional effect.
REQ-003 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per tenure, legal range 1..255.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 Port: Request  input  16  per-requester request; bit k = requester k.
REQ-007 Port: Release  input  1  current owner ends tenure this cycle.
REQ-008 Port: Selector  output  8  index of granted requester, driven straight into the 16-way demux selector.
REQ-009 Port: Disable  output  1  demux disable; 1 = no requester owns the shared strobe.
REQ-010 Port: Grant  output  16  one-hot grant; Grant[k]=1 iff owner is k.
REQ-011 Port: Busy  output  1  1 while state is GRANT.

Function
REQ-012 The block SHALL implement two states, IDLE and GRANT, plus a 4-bit round-robin pointer PTR and an 8-bit tenure counter HCNT, all registered.
REQ-013 Arbitration SHALL select the first k with Request[k]=1, searching k = PTR, PTR+1, ... wrapping modulo 16.
REQ-014 IDLE: if any Request bit is 1 at an edge, the block SHALL enter GRANT with owner = arbitration result, HCNT=0; otherwise remain IDLE.
REQ-015 Grant latency SHALL be exactly one cycle: request sampled at edge N, Grant/Selector/Disable updated after edge N.
REQ-016 GRANT: tenure SHALL end at an edge when any of: Release=1; Request[owner]=0; HCNT = MAX_HOLD-1.
REQ-017 Otherwise in GRANT, HCNT SHALL increment by 1 and owner SHALL be unchanged.
REQ-018 On tenure end, PTR SHALL become (owner+1) mod 16 and arbitration SHALL be re-run in the same cycle using the new PTR with the owner's request bit masked.
REQ-019 If that re-arbitration finds a requester, the block SHALL stay in GRANT with the new owner and HCNT=0 (back-to-back, no idle cycle); else go to IDLE.
REQ-020 A sole requester whose tenure ends by MAX_HOLD SHALL see exactly one IDLE cycle before re-grant (masking rule of REQ-018).
REQ-021 PTR SHALL change only on tenure end; it SHALL NOT change while IDLE.
REQ-022 Selector[3:0] SHALL equal owner index and Selector[7:4] SHALL be 0 in GRANT; Selector SHALL be 8'h00 in IDLE.
REQ-023 Disable SHALL be 0 in GRANT and 1 in IDLE; Grant SHALL be 16'h0000 in IDLE.
REQ-024 Grant SHALL never have more than one bit set, and Grant[Selector[3:0]] SHALL be 1 whenever Disable=0.
REQ-025 Release asserted in IDLE SHALL be ignored.
REQ-026 All outputs SHALL be registered; no combinational path from Request or Release to any output.

Reset
REQ-027 With rst=0 at an edge: state=IDLE, PTR=0, HCNT=0, Selector=8'h00, Disable=1, Grant=16'h0000, Busy=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-tenure; the tenure SHALL be aborted with no PTR update.
REQ-029 The first arbitration after reset release SHALL use PTR=0.

Verification
REQ-030 Reset then Request=16'h0005 held -> after 1 cycle Selector=0, Grant=16'h0001, Disable=0; after 4 cycles (MAX_HOLD=4) Selector=2, Grant=16'h0004 with no idle gap.
REQ-031 Request=16'h8000 only, MAX_HOLD=4 -> Grant=16'h8000 for 4 cycles, 1 IDLE cycle (Disable=1, Selector=0), re-grant; PTR wraps to 0.
REQ-032 Owner 3 granted, Release=1 on its 2nd grant cycle, Request=16'hFFFF -> next owner 4, Selector=8'h04.
REQ-033 Owner 5 granted, Request[5] drops, no other requests -> next cycle IDLE, Disable=1, Busy=0, Grant=0.
REQ-034 rst=0 asserted mid-tenure with owner 9 -> next cycle all outputs at reset values; after release with Request=16'h0300 owner is 8.
REQ-035 Random Request/Release for 10k cycles -> Grant one-hot or zero, Grant/Selector/Disable consistent, every persistent requester granted within 16*MAX_HOLD+16 cycles.

Source files
------------

// File: rtl/demux16_rr_arbiter.sv
// demux16_rr_arbiter
//   Round-robin owner arbiter for a 16-way demux that shares one strobe.
//   One requester owns the strobe per tenure. A tenure lasts at most MAX_HOLD
//   cycles. It also ends early on Release or when the owner drops its request.
//   Ports:
//     clk      - clock, all state updates on the rising edge
//     rst      - synchronous active-low reset
//     Request  - [15:0] per-requester request lines
//     Release  - current owner ends its tenure this cycle
//     Selector - [7:0] owner index for the demux select (0 when idle)
//     Disable  - 1 when nobody owns the strobe
//     Grant    - [15:0] one-hot owner, 0 when idle
//     Busy     - 1 while a tenure is active
module demux16_rr_arbiter #(
  parameter int UUID     = 0,
  parameter     NAME     = "",
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Request,
  input  logic        Release,
  output logic [7:0]  Selector,
  output logic        Disable,
  output logic [15:0] Grant,
  output logic        Busy
);

  localparam int NUM_LANES = 16;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Identification parameters only tag the instance.
  if (UUID < 0 && $bits(NAME) == 0) begin : g_id_tag
  end

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [3:0]  owner, owner_n;
  logic [7:0]  hcnt, hcnt_n;
  logic [NUM_LANES-1:0] gnt_n;

  // First requester at or after 'start', wrapping mod 16. Bit 4 = found.
  // The loop runs downwards so the closest match is the last one assigned.
  function automatic logic [4:0] arb(input logic [NUM_LANES-1:0] req,
                                     input logic [3:0] start);
    logic [3:0] k;
    arb = '0;
    for (int i = NUM_LANES-1; i >= 0; i--) begin
      k = start + 4'(i);
      if (req[k]) arb = {1'b1, k};
    end
  endfunction

  logic [4:0]  arb_idle, arb_next;
  logic [3:0]  ptr_adv;
  logic        tenure_end;

  always_comb begin
    ptr_adv    = owner + 4'd1;
    tenure_end = Release | ~Request[owner] | (hcnt == 8'(MAX_HOLD - 1));
    arb_idle   = arb(Request, ptr);
    // The departing owner is masked so the others get a turn. A lone
    // requester therefore sees one idle cycle after a MAX_HOLD expiry.
    arb_next   = arb(Request & ~(NUM_LANES'(1) << owner), ptr_adv);

    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    hcnt_n  = hcnt;
    case (state)
      IDLE: begin
        if (arb_idle[4]) begin
          state_n = GRANT;
          owner_n = arb_idle[3:0];
          hcnt_n  = '0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          ptr_n  = ptr_adv;
          hcnt_n = '0;
          if (arb_next[4]) begin
            owner_n = arb_next[3:0];
          end else begin
            state_n = IDLE;
            owner_n = '0;
          end
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Per-lane grant decode of the next owner.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign gnt_n[g] = (state_n == GRANT) && (owner_n == 4'(g));
  end

  // Outputs are registered from the next-state values, which keeps the
  // one-cycle grant latency with no combinational input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hcnt     <= '0;
      Selector <= 8'h00;
      Disable  <= 1'b1;
      Grant    <= '0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      hcnt     <= hcnt_n;
      Selector <= (state_n == GRANT) ? {4'h0, owner_n} : 8'h00;
      Disable  <= (state_n != GRANT);
      Grant    <= gnt_n;
      Busy     <= (state_n == GRANT);
    end
  end

endmodule

// File: tb/tb_demux16_rr_arbiter.sv
// Testbench for demux16_rr_arbiter.
// The driver applies inputs on the falling edge. It advances a tenure-level
// reference model and queues the outputs expected after the next rising edge.
// The monitor pops one entry per cycle and compares it. The monitor also
// tracks how long each requester has waited without being granted.
module tb_demux16_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int BOUND    = 16*MAX_HOLD + 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        rel;
  logic [7:0]  sel;
  logic        dis;
  logic [15:0] gnt;
  logic        busy;

  always #5 clk = ~clk;

  demux16_rr_arbiter #(.UUID(7), .NAME("dut"), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst_n), .Request(req), .Release(rel),
    .Selector(sel), .Disable(dis), .Grant(gnt), .Busy(busy)
  );

  typedef struct {
    logic [7:0]  sel;
    logic [15:0] gnt;
    logic        dis;
    logic        busy;
    logic        rst_n;
    logic [15:0] req;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   max_wait = 0;

  // Reference model: the owner is -1 when idle. The tenure length is a plain
  // count of cycles spent granted.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_len   = 0;

  function automatic int first_req(logic [15:0] r, int start);
    for (int i = 0; i < 16; i++)
      if (r[(start + i) % 16]) return (start + i) % 16;
    return -1;
  endfunction

  task automatic step(input logic [15:0] r, input logic rl, input logic rs);
    exp_t e;
    logic [15:0] m;
    req = r; rel = rl; rst_n = rs;
    if (!rs) begin
      m_owner = -1; m_ptr = 0; m_len = 0;
    end else if (m_owner < 0) begin
      m_owner = first_req(r, m_ptr);
      m_len   = 1;
    end else if (rl || !r[m_owner] || m_len == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 16;
      m = r;
      m[m_owner] = 1'b0;
      m_owner = first_req(m, m_ptr);
      m_len   = 1;
    end else begin
      m_len++;
    end
    e.sel   = (m_owner < 0) ? 8'h00 : 8'(m_owner);
    e.gnt   = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
    e.dis   = (m_owner < 0);
    e.busy  = (m_owner >= 0);
    e.rst_n = rs;
    e.req   = r;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] r, input logic rl, input int n);
    for (int i = 0; i < n; i++) step(r, rl, 1'b1);
  endtask

  // Monitor
  initial begin : monitor
    exp_t e;
    int wait_cnt [16];
    for (int k = 0; k < 16; k++) wait_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sel !== e.sel || gnt !== e.gnt || dis !== e.dis || busy !== e.busy) begin
          errors++;
          $display("FAIL outputs t=%0t got sel=%h gnt=%h dis=%b busy=%b exp sel=%h gnt=%h dis=%b busy=%b",
                   $time, sel, gnt, dis, busy, e.sel, e.gnt, e.dis, e.busy);
        end
        checks++;
        if (!$onehot0(gnt) || (!dis && !gnt[sel[3:0]]) || (!dis && sel[7:4] != 4'h0)) begin
          errors++;
          $display("FAIL consistency t=%0t got sel=%h gnt=%h dis=%b, want one-hot grant matching selector",
                   $time, sel, gnt, dis);
        end
        for (int k = 0; k < 16; k++) begin
          if (!e.rst_n || !e.req[k] || gnt[k]) wait_cnt[k] = 0;
          else wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
    end
  end

  // Driver
  initial begin : driver
    logic [15:0] r;
    logic        rl, rs;
    int          guard;
    req = '0; rel = 1'b0; rst_n = 1'b0;

    // Reset, then two requesters held: owner 0 for MAX_HOLD, then owner 2 back-to-back.
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    hold(16'h0005, 1'b0, 12);

    // Sole requester 15: expiry, one idle cycle, re-grant, pointer wraps.
    step(16'h0000, 1'b0, 1'b0);
    hold(16'h8000, 1'b0, 12);

    // Owner 3 released on its second cycle while everyone requests.
    step(16'h0000, 1'b0, 1'b0);
    hold(16'h0008, 1'b0, 1);
    hold(16'hFFFF, 1'b0, 1);
    hold(16'hFFFF, 1'b1, 1);
    hold(16'hFFFF, 1'b0, 3);

    // Owner 5 drops its request with no other requesters, then Release while idle.
    step(16'h0000, 1'b0, 1'b0);
    hold(16'h0020, 1'b0, 2);
    hold(16'h0000, 1'b0, 1);
    hold(16'h0000, 1'b1, 3);

    // Reset mid-tenure with owner 9, then 8 and 9 request with the pointer at 0.
    step(16'h0000, 1'b0, 1'b0);
    hold(16'h0200, 1'b0, 2);
    step(16'h0200, 1'b0, 1'b0);
    hold(16'h0300, 1'b0, 6);

    // Random traffic: sticky request bits, occasional release, rare resets.
    r = 16'($urandom);
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 16; k++)
        if ($urandom_range(31) == 0) r[k] = ~r[k];
      rl = ($urandom_range(7) == 0);
      rs = ($urandom_range(999) != 0);
      step(r, rl, rs);
    end
    step(16'h0000, 1'b0, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries, want 0", exp_q.size());
    end
    checks++;
    if (max_wait > BOUND) begin
      errors++;
      $display("FAIL starvation got max wait %0d cycles, want <= %0d", max_wait, BOUND);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
